// File: rtl/chipset.sv
// chipset: UART boot loader that copies BOOT_LEN bytes into RAM, then hands the bus to the CPU.
// Define CHIPSET_UART_TX_EN to include the UART transmit register (0xFF01) and status (0xFF00).
module chipset #(
  parameter int CLK_HZ   = 4096000,
  parameter int BAUD     = 115200,
  parameter int BOOT_LEN = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Phi2,
  input  logic       RXpin,
  output logic       TXpin,
  input  logic       WR,
  inout  wire        WE,
  output logic       RD,
  output logic       CS,
  output logic       CPUCLK,
  inout  wire  [7:0] BUSAL,
  input  logic [7:0] BUSAH,
  inout  wire  [7:0] DBUS
);

  localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int DW       = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WR_IDLE, WR_SETUP, WR_LOW1, WR_LOW2, WR_HOLD} boot_wr_t;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [DW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid;

  boot_wr_t      wr_state_q, wr_state_d;
  logic [8:0]    boot_cnt_q, boot_cnt_d;
  logic [7:0]    boot_data_q, boot_data_d;
  logic          run_q, run_d;
  logic [1:0]    cpu_div_q;

  logic          io_page, rd_status, boot_oe, dbus_oe, we_n, tx_busy;
  logic [7:0]    dbus_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      wr_state_q  <= WR_IDLE;
      boot_cnt_q  <= '0;
      boot_data_q <= '0;
      run_q       <= 1'b0;
      cpu_div_q   <= '0;
    end else begin
      rx_meta_q   <= RXpin;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      wr_state_q  <= wr_state_d;
      boot_cnt_q  <= boot_cnt_d;
      boot_data_q <= boot_data_d;
      run_q       <= run_d;
      if (run_q) cpu_div_q <= cpu_div_q + 2'd1;
    end
  end

  // 8N1 receiver: every bit, including start and stop, is sampled at its midpoint
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = DW'(HALF_DIV - 1);
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = DW'(BAUD_DIV - 1);
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - DW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = DW'(BAUD_DIV - 1);
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - DW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_valid   = rx_sync_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - DW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Boot write cycle: setup, two WE-low cycles, hold, then advance the address
  always_comb begin
    wr_state_d  = wr_state_q;
    boot_cnt_d  = boot_cnt_q;
    boot_data_d = boot_data_q;
    run_d       = run_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (!run_q && rx_valid) begin
          wr_state_d  = WR_SETUP;
          boot_data_d = rx_shift_q;
        end
      end
      WR_SETUP: wr_state_d = WR_LOW1;
      WR_LOW1:  wr_state_d = WR_LOW2;
      WR_LOW2:  wr_state_d = WR_HOLD;
      WR_HOLD: begin
        wr_state_d = WR_IDLE;
        boot_cnt_d = boot_cnt_q + 9'd1;
        if (boot_cnt_q == 9'(BOOT_LEN - 1)) run_d = 1'b1;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign io_page   = (BUSAH == 8'hFF);
  assign rd_status = run_q && io_page && (BUSAL == 8'h00) && WR && Phi2;
  assign boot_oe   = (wr_state_q != WR_IDLE);

  always_comb begin
    CS   = 1'b1;
    RD   = 1'b1;
    we_n = 1'b1;
    if (run_q) begin
      we_n = WR;
      if (!io_page) begin
        CS = 1'b0;
        RD = ~WR;
      end
    end else begin
      CS   = 1'b0;
      we_n = !((wr_state_q == WR_LOW1) || (wr_state_q == WR_LOW2));
    end
    // RAM must stay deselected for the whole time reset is held
    if (!reset) CS = 1'b1;
  end

  assign CPUCLK   = cpu_div_q[1];
  assign WE       = we_n;
  assign dbus_oe  = boot_oe || rd_status;
  assign dbus_out = boot_oe ? boot_data_q : {7'b0, tx_busy};
  assign DBUS     = dbus_oe ? dbus_out : 8'bz;
  assign BUSAL    = boot_oe ? boot_cnt_q[7:0] : 8'bz;

`ifdef CHIPSET_UART_TX_EN
  logic          wr_strobe, wr_seen_q, tx_start, tx_busy_q, tx_q;
  logic [8:0]    tx_shift_q;
  logic [DW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;

  assign wr_strobe = run_q && !WR && Phi2;
  assign tx_start  = wr_strobe && !wr_seen_q && io_page && (BUSAL == 8'h01) && !tx_busy_q;

  // tx_bit_q counts frame bits already sent; bit 9 is the stop bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_seen_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      wr_seen_q <= wr_strobe;
      if (tx_start) begin
        tx_busy_q  <= 1'b1;
        tx_q       <= 1'b0;
        tx_shift_q <= {1'b1, DBUS};
        tx_cnt_q   <= DW'(BAUD_DIV - 1);
        tx_bit_q   <= '0;
      end else if (tx_busy_q) begin
        if (tx_cnt_q == '0) begin
          tx_cnt_q <= DW'(BAUD_DIV - 1);
          if (tx_bit_q == 4'd9) begin
            tx_busy_q <= 1'b0;
            tx_q      <= 1'b1;
          end else begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            tx_bit_q   <= tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q - DW'(1);
        end
      end
    end
  end

  assign tx_busy = tx_busy_q;
  assign TXpin   = tx_q;
`else
  assign tx_busy = 1'b0;
  assign TXpin   = 1'b1;
`endif

endmodule

// File: tb/tb_chipset.sv
// tb_chipset: boots a short image over RX, checks RAM write cycles, RUN decode, CPU clock and TX.
// Build with +define+CHIPSET_UART_TX_EN to exercise the transmit path instead of its disabled form.
`timescale 1ns/1ps
module tb_chipset;

  localparam int BOOT_LEN = 16;
  localparam int BD       = 36;

  logic       clk = 1'b0;
  logic       reset, Phi2, RXpin, WR;
  logic [7:0] BUSAH;
  logic       TXpin, RD, CS, CPUCLK;
  wire        WE;
  wire  [7:0] BUSAL, DBUS;
  logic [7:0] busal_drv, dbus_drv;
  logic       busal_en, dbus_en;

  assign BUSAL = busal_en ? busal_drv : 8'bz;
  assign DBUS  = dbus_en ? dbus_drv : 8'bz;

  chipset #(.BOOT_LEN(BOOT_LEN)) dut (
    .clk(clk), .reset(reset), .Phi2(Phi2), .RXpin(RXpin), .TXpin(TXpin),
    .WR(WR), .WE(WE), .RD(RD), .CS(CS), .CPUCLK(CPUCLK),
    .BUSAL(BUSAL), .BUSAH(BUSAH), .DBUS(DBUS)
  );

  always #122 clk = ~clk;

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} boot_exp_t;
  typedef struct {
    logic [7:0] ah;
    logic [7:0] al;
    logic       wr;
    logic       phi2;
    logic       exp_cs;
    logic       exp_rd;
  } dec_vec_t;

  boot_exp_t exp_q[$];
  logic      tx_exp_q[$];
  dec_vec_t  vecs[7];
  int        n_cmp = 0;
  int        n_fail = 0;
  int        pulses = 0;
  logic      mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // nbits < 8 stops mid-frame, leaving the line at the last data bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
    RXpin = 1'b0;
    tick(BD);
    for (int k = 0; k < nbits; k++) begin
      RXpin = b[k];
      tick(BD);
    end
    if (nbits == 8) begin
      RXpin = stop_bit;
      tick(BD);
      RXpin = 1'b1;
      tick(BD);
    end
  endtask

  task automatic cpu_write(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] d, input int ns);
    BUSAH = ah; busal_drv = al; dbus_drv = d; dbus_en = 1'b1;
    WR = 1'b0; Phi2 = 1'b1;
    #(ns);
    WR = 1'b1; Phi2 = 1'b0; dbus_en = 1'b0;
    tick(1);
  endtask

  task automatic cpu_read_status(output logic [7:0] r);
    BUSAH = 8'hFF; busal_drv = 8'h00; dbus_en = 1'b0;
    WR = 1'b1; Phi2 = 1'b1;
    tick(1);
    r = DBUS;
    Phi2 = 1'b0;
    $display("cpu read 0xFF00 -> %02h", r);
  endtask

  task automatic txpin_idle(input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      if (TXpin !== 1'b1) bad++;
      tick(1);
    end
    check("txpin_idle", 32'(bad), 32'd0);
  endtask

  // Boot write monitor: one scoreboard pop per completed WE pulse
  initial begin
    int        low_cnt = 0;
    logic      we_prev = 1'b1;
    boot_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (WE === 1'b0) begin
          low_cnt++;
        end else if (we_prev === 1'b0) begin
          pulses++;
          check("we_low_width", 32'(low_cnt), 32'd2);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %02h data %02h, expected no write", BUSAL, DBUS);
          end else begin
            e = exp_q.pop_front();
            $display("boot write addr %02h data %02h (want %02h %02h)", BUSAL, DBUS, e.addr, e.data);
            check("boot_addr", 32'(BUSAL), 32'(e.addr));
            check("boot_data", 32'(DBUS), 32'(e.data));
          end
          low_cnt = 0;
        end
        we_prev = WE;
      end else begin
        we_prev = 1'b1;
        low_cnt = 0;
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] pat;
    int         bad;

    reset = 1'b0; RXpin = 1'b1; WR = 1'b1; Phi2 = 1'b0; BUSAH = 8'h00;
    busal_drv = 8'h00; dbus_drv = 8'h00; busal_en = 1'b0; dbus_en = 1'b0;

    vecs[0] = '{8'h12, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'hFE, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1};

    #10000;
    check("rst_txpin", 32'(TXpin), 32'd1);
    check("rst_we", 32'(WE), 32'd1);
    check("rst_rd", 32'(RD), 32'd1);
    check("rst_cs", 32'(CS), 32'd1);
    check("rst_cpuclk", 32'(CPUCLK), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (CPUCLK !== 1'b0 || WE !== 1'b1) bad++;
    end
    check("idle_boot", 32'(bad), 32'd0);

    RXpin = 1'b0;
    tick(5);
    RXpin = 1'b1;
    tick(400);
    check("glitch_no_write", 32'(pulses), 32'd0);

    send_frame(8'h55, 1'b0, 8);
    tick(50);
    check("framing_no_write", 32'(pulses), 32'd0);

    exp_q.push_back({8'h00, 8'h3C});
    send_frame(8'h3C, 1'b1, 8);
    exp_q.push_back({8'h01, 8'hC3});
    send_frame(8'hC3, 1'b1, 8);
    check("pre_abort_writes", 32'(pulses), 32'd2);

    send_frame(8'hF0, 1'b1, 3);
    reset = 1'b0;
    #1000;
    check("abort_we", 32'(WE), 32'd1);
    check("abort_cs", 32'(CS), 32'd1);
    RXpin = 1'b1;
    #1000;
    reset = 1'b1;
    pulses = 0;
    tick(50);

    for (int i = 0; i < BOOT_LEN - 1; i++) begin
      exp_q.push_back({8'(i), 8'(8'h85 + i)});
      send_frame(8'(8'h85 + i), 1'b1, 8);
    end

    exp_q.push_back({8'(BOOT_LEN - 1), 8'(8'h85 + BOOT_LEN - 1)});
    pat = 8'b1100_1100;
    fork
      send_frame(8'(8'h85 + BOOT_LEN - 1), 1'b1, 8);
      begin
        int n = 0;
        while (WE !== 1'b0 && n < 1000) begin tick(1); n++; end
        while (WE !== 1'b1 && n < 1000) begin tick(1); n++; end
        check("last_write_seen", 32'(n < 1000), 32'd1);
        for (int j = 0; j < 8; j++) begin
          tick(1);
          check("cpuclk_after_run", 32'(CPUCLK), 32'(pat[j]));
        end
      end
    join
    tick(5);
    mon_en = 1'b0;
    check("boot_pulse_count", 32'(pulses), 32'(BOOT_LEN));
    check("boot_queue_empty", 32'(exp_q.size()), 32'd0);

    busal_en = 1'b1;
    for (int v = 0; v < 7; v++) begin
      BUSAH = vecs[v].ah; busal_drv = vecs[v].al; WR = vecs[v].wr; Phi2 = vecs[v].phi2;
      dbus_drv = 8'h00; dbus_en = !vecs[v].wr;
      tick(1);
      $display("decode AH %02h AL %02h WR %0b -> CS %0b RD %0b WE %0b", vecs[v].ah, vecs[v].al,
               vecs[v].wr, CS, RD, WE);
      check("run_cs", 32'(CS), 32'(vecs[v].exp_cs));
      check("run_rd", 32'(RD), 32'(vecs[v].exp_rd));
      check("run_we", 32'(WE), 32'(vecs[v].wr));
      check("run_busal_released", 32'(BUSAL), 32'(vecs[v].al));
      if (dbus_en) check("run_dbus_released", 32'(DBUS), 32'h00);
    end
    WR = 1'b1; Phi2 = 1'b0; dbus_en = 1'b0;
    tick(2);
    check("tx_idle_before", 32'(TXpin), 32'd1);

`ifdef CHIPSET_UART_TX_EN
    tx_exp_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fork
      begin
        int   n = 0;
        int   low = 0;
        logic first;
        while (TXpin !== 1'b0 && n < 40) begin tick(1); n++; end
        check("tx_start_seen", 32'(n < 40), 32'd1);
        first = TXpin;
        check("tx_bit0", 32'(first), 32'(tx_exp_q.pop_front()));
        while (TXpin === 1'b0 && low < 100) begin tick(1); low++; end
        check("tx_start_len", 32'(low), 32'd36);
        tick(18);
        for (int b = 1; b < 10; b++) begin
          $display("tx bit %0d = %0b", b, TXpin);
          check("tx_bit", 32'(TXpin), 32'(tx_exp_q.pop_front()));
          if (b < 9) tick(36);
        end
      end
      begin
        cpu_write(8'hFF, 8'h01, 8'h01, 800);
        tick(100);
        cpu_write(8'hFF, 8'h01, 8'hAA, 800);
        tick(50);
        cpu_read_status(r);
        check("status_busy", 32'(r), 32'h01);
      end
    join
`else
    fork
      txpin_idle(400);
      begin
        cpu_write(8'hFF, 8'h01, 8'h01, 800);
        tick(100);
        cpu_write(8'hFF, 8'h01, 8'hAA, 800);
        tick(50);
        cpu_read_status(r);
        check("status_no_tx", 32'(r), 32'h00);
      end
    join
`endif
    tick(30);
    cpu_read_status(r);
    check("status_idle", 32'(r), 32'h00);
    txpin_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/chipset.md
CHIPSET -- requirements
Module: chipset

Interface
REQ-001 SHALL have parameter CLK_HZ, default 4096000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: UART bit rate; bit period BAUD_DIV = round(CLK_HZ/BAUD) = 36 clk.
REQ-003 SHALL have parameter BOOT_LEN, default 256: number of bytes loaded at boot (1..256).
REQ-004 SHALL have one clock and an asynchronous active-low reset; clock and reset ports are named clk and reset.
REQ-005 Ports (name direction width meaning):
- clk in 1: system clock.
- reset in 1: async active-low reset.
- Phi2 in 1: CPU phase-2 strobe, qualifies CPU bus cycles.
- RXpin in 1: UART receive, idle high.
- TXpin out 1: UART transmit, idle high.
- WR in 1: CPU write strobe, active low.
- WE inout 1: RAM write enable, active low.
- RD out 1: RAM output enable, active low.
- CS out 1: RAM chip select, active low.
- CPUCLK out 1: CPU clock.
- BUSAL inout 8: address bus low byte.
- BUSAH in 8: address bus high byte.
- DBUS inout 8: data bus.

Function
REQ-006 SHALL synchronise RXpin through two flip-flops before use.
REQ-007 UART RX SHALL decode 8N1, LSB first:
- falling edge starts a frame; bits are sampled at mid-bit, BAUD_DIV/2 clk after the edge.
- start bit sampled high -> false start, return to idle.
- stop bit sampled low -> framing error, byte discarded.
REQ-008 Operating states are BOOT and RUN; after reset the state SHALL be BOOT with a byte counter of 0.
REQ-009 BOOT, per valid RX byte:
- drive BUSAL = counter and DBUS = byte.
- 1 clk later drive WE low for 2 clk, then high.
- hold address and data 1 clk after WE rises, then increment the counter.
REQ-010 BOOT bus state:
- CS low, RD high, CPUCLK held low.
- Phi2 and WR ignored.
REQ-011 When the counter reaches BOOT_LEN, the state SHALL become RUN; RUN persists until reset.
REQ-012 RUN releases the bus: BUSAL and DBUS tri-stated except as in REQ-015; WE driven equal to WR.
REQ-013 CPUCLK in RUN SHALL be clk/4 with 50 % duty, first rising edge 2 clk after entering RUN.
REQ-014 Decode in RUN, I/O page is BUSAH==8'hFF:
- I/O page: CS high, RD high.
- otherwise: CS low, RD = ~WR.
REQ-015 CPU read of 8'hFF00 (WR high, Phi2 high) SHALL drive DBUS = {7'b0, tx_busy}; in RUN DBUS is otherwise tri-stated.
REQ-016 CPU write to 8'hFF01:
- DBUS captured on the rising clk edge where WR low and Phi2 high are first both seen.
- captured byte is sent as an 8N1 frame on TXpin.
- tx_busy is set from capture until the end of the stop bit.
REQ-017 A write to 8'hFF01 while tx_busy SHALL be ignored; writes to other I/O addresses SHALL have no effect.
REQ-018 RX bytes received in RUN SHALL be discarded; the receiver keeps running.

Reset
REQ-019 While reset is low:
- TXpin=1, WE=1, RD=1, CS=1, CPUCLK=0.
- BUSAL and DBUS tri-stated.
- state=BOOT, counter=0, tx_busy=0, RX/TX idle.
REQ-020 Reset asserted mid-frame or mid-write SHALL abort immediately; the boot restarts from address 0 after release.

Configuration
REQ-021 With macro CHIPSET_UART_TX_EN defined, the TX path and status of REQ-015/016 SHALL be present.
REQ-022 Without CHIPSET_UART_TX_EN:
- TXpin is constant 1.
- a read of 8'hFF00 returns 8'h00.
- writes to 8'hFF01 are ignored.

Verification
REQ-023 Reset low 10 us, then high; RX stays idle -> CPUCLK stays 0, WE stays 1, state stays BOOT.
REQ-024 Send bytes 8'h85+i (mod 256), i=0..255, at 115200 baud with one idle bit between frames -> 256 WE low pulses of 2 clk each; at WE rise, BUSAL=i and DBUS=8'h85+i.
REQ-025 After the 256th byte -> state RUN, CPUCLK toggles every 2 clk, and BUSAL/DBUS are released to Z.
REQ-026 Glitch: RX low for 5 clk -> no byte accepted. Stop bit forced 0 -> no WE pulse and the counter does not advance.
REQ-027 In RUN, CPU writes 8'h01 to 8'hFF01 (WR low 800 ns) -> TXpin sends 0,1,0,0,0,0,0,0,0,1, 36 clk per bit. A read of 8'hFF00 returns 8'h01 during the frame and 8'h00 after it.
REQ-028 A second write to 8'hFF01 while busy -> ignored; the first frame is unchanged.
